// File: rtl/f36_tx_arbiter_pkg.sv
// Shared FIFO36 word layout and arbiter state encoding for the MAC TX path.
package f36_tx_arbiter_pkg;

    localparam int F36_W  = 36;
    localparam int SOF    = 32;
    localparam int EOF    = 33;
    localparam int OCC_LO = 34;
    localparam int OCC_HI = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PORT0 = 2'd1,
        PORT1 = 2'd2
    } state_t;

endpackage

// File: rtl/f36_tx_arbiter_rr_pick2.sv
// Combinational 2-way winner selector: round-robin against the last grant,
// or fixed priority to port 0.
module f36_tx_arbiter_rr_pick2
    import f36_tx_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic [1:0] cand,
    input  logic       last_grant,
    output logic       any,
    output logic       winner
);

    logic contested_pick;

    assign contested_pick = (PRIO_MODE != 0) ? 1'b0 : ~last_grant;
    assign any            = |cand;
    // A lone candidate always wins; the tie rule applies only when both request.
    assign winner         = (cand == 2'b11) ? contested_pick : cand[1];

endmodule

// File: rtl/f36_tx_arbiter.sv
// Frame-atomic 2:1 arbiter feeding the MAC wrapper's single FIFO36 TX port,
// with per-port frame counters and an out-of-frame drop counter.
module f36_tx_arbiter
    import f36_tx_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [F36_W-1:0]   in0_data,
    input  logic               in0_src_rdy,
    output logic               in0_dst_rdy,
    input  logic [F36_W-1:0]   in1_data,
    input  logic               in1_src_rdy,
    output logic               in1_dst_rdy,
    output logic [F36_W-1:0]   out_data,
    output logic               out_src_rdy,
    input  logic               out_dst_rdy,
    input  logic               enable,
    output logic               busy,
    output logic               grant,
    output logic [CNT_W-1:0]   frames0,
    output logic [CNT_W-1:0]   frames1,
    output logic [CNT_W-1:0]   drops
);

    state_t     state, state_nxt;
    logic       grant_nxt;
    logic       rst_any;
    logic [1:0] cand;
    logic       pick_any, pick_win;
    logic       done0, done1;
    logic       drop0, drop1;

    assign rst_any = reset | clear;
    assign cand    = {in1_src_rdy & in1_data[SOF], in0_src_rdy & in0_data[SOF]};
    assign busy    = (state != IDLE);

    f36_tx_arbiter_rr_pick2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .cand       (cand),
        .last_grant (grant),
        .any        (pick_any),
        .winner     (pick_win)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        out_data    = in0_data;
        out_src_rdy = 1'b0;
        in0_dst_rdy = 1'b0;
        in1_dst_rdy = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        drop0       = 1'b0;
        drop1       = 1'b0;

        case (state)
            IDLE: begin
                // Words that do not open a frame are swallowed to resynchronise.
                drop0       = in0_src_rdy & ~in0_data[SOF];
                drop1       = in1_src_rdy & ~in1_data[SOF];
                in0_dst_rdy = drop0;
                in1_dst_rdy = drop1;
                if (enable && pick_any) begin
                    state_nxt = pick_win ? PORT1 : PORT0;
                    grant_nxt = pick_win;
                end
            end
            PORT0: begin
                out_data    = in0_data;
                out_src_rdy = in0_src_rdy;
                in0_dst_rdy = out_dst_rdy;
                if (in0_src_rdy && out_dst_rdy && in0_data[EOF]) begin
                    state_nxt = IDLE;
                    done0     = 1'b1;
                end
            end
            PORT1: begin
                out_data    = in1_data;
                out_src_rdy = in1_src_rdy;
                in1_dst_rdy = out_dst_rdy;
                if (in1_src_rdy && out_dst_rdy && in1_data[EOF]) begin
                    state_nxt = IDLE;
                    done1     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Nothing is accepted or offered while a reset is being applied.
        if (rst_any) begin
            in0_dst_rdy = 1'b0;
            in1_dst_rdy = 1'b0;
            out_src_rdy = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_any) begin
            state   <= IDLE;
            grant   <= 1'b0;
            frames0 <= '0;
            frames1 <= '0;
            drops   <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            if (done0) frames0 <= frames0 + CNT_W'(1);
            if (done1) frames1 <= frames1 + CNT_W'(1);
            drops   <= drops + CNT_W'(drop0) + CNT_W'(drop1);
        end
    end

endmodule
